pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and next-address stage for the MIPS processor. It sits directly downstream of the ALU and consumes `aluZero` for branch resolution and `aluOverflow` for trapping add/sub. It also takes jump and jump-register requests from the control path. It holds the architectural PC and the exception state (EPC, cause code, exception counter), and supplies `pc` to instruction fetch.

## Interface

Parameters
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `EXC_VECTOR`, 32'h0000_0180, exception handler entry address.

Ports
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pcEnable` in 1: 1 = advance the PC this cycle; 0 = stall and hold all state.
- `branch` in 1: the current instruction is a conditional branch.
- `aluZero` in 1: ALU zero flag; the branch is taken when `branch & aluZero`.
- `branchOffset` in 32: sign-extended immediate, in words.
- `jump` in 1: the current instruction is j/jal.
- `jumpTarget` in 26: instruction index field.
- `jumpReg` in 1: the current instruction is jr.
- `jumpRegAddr` in 32: register operand for jr.
- `ovfTrap` in 1: the current instruction is a trapping add/sub.
- `aluOverflow` in 1: ALU overflow flag.
- `eret` in 1: return from exception.
- `pc` out 32: current PC (registered).
- `pcPlus4` out 32: `pc + 4` (combinational, wraps modulo 2^32).
- `epc` out 32: address of the last faulting instruction.
- `cause` out 5: last exception code; 12 = overflow, 4 = address error.
- `flush` out 1: combinational; suppresses register and memory writes of the faulting instruction.
- `excTaken` out 1: registered one-cycle pulse in the first cycle the PC sits at the handler.
- `excCount` out 8: number of exceptions taken; saturates at 255.

## Operation

- **Exception conditions**, evaluated only when `pcEnable` = 1:
  - Overflow (Ov): `ovfTrap & aluOverflow`.
  - Address error (AdEL): `jumpReg` with `jumpRegAddr[1:0]` != 0.
  - If both conditions hold in the same cycle, overflow wins and `cause` = 12.
- **`flush`** = 1 whenever an exception condition holds with `pcEnable` = 1; otherwise 0.
- **Next-PC priority**, highest first:
  1. Exception: next = `EXC_VECTOR`; `epc` <= `pc`; `cause` <= code; `excCount` increments, saturating at 255.
  2. `eret`: next = `epc`.
  3. `jumpReg`: next = `jumpRegAddr`.
  4. `jump`: next = {`pcPlus4[31:28]`, `jumpTarget`, 2'b00}.
  5. `branch & aluZero`: next = `pcPlus4 + (branchOffset << 2)`, truncated to 32 bits. Backward offsets wrap correctly.
  6. Otherwise: next = `pcPlus4`.
- **Stall** (`pcEnable` = 0): `pc`, `epc`, `cause` and `excCount` hold. `flush` = 0 and `excTaken` is cleared on that edge. Control inputs present during a stall are ignored.
- **`epc` and `cause`** change only when an exception is taken. `eret` does not modify them.
- **Address wrap**: `pc` = 32'hFFFF_FFFC with no control asserted gives next `pc` = 32'h0000_0000.
- **Undefined combinations**: simultaneous `jump`/`jumpReg`/`branch` are resolved by the priority list above; no error is raised.

## Timing

- **Reset**: `rst_n` = 0 sampled on a rising edge loads `pc` = `RESET_PC`, `epc` = 0, `cause` = 0, `excTaken` = 0, `excCount` = 0.
  - Reset overrides `pcEnable` = 0 and any pending exception. A reset in the same cycle as an overflow records nothing.
- **Latency**: all control inputs are sampled at the rising edge and the new `pc` is visible immediately after it, i.e. one cycle per instruction. `pcPlus4` follows `pc` combinationally in the same cycle.
- **`flush`**: valid in the same cycle as the faulting inputs, before the edge. No registered delay.
- **`excTaken`**: high for exactly the one cycle after the exception edge, with `pc` = `EXC_VECTOR` in that cycle.
  - Back-to-back exceptions produce consecutive pulses.
  - `excTaken` is not asserted after `eret`.
- **No combinational path** exists from any input to `pc`, `epc`, `cause`, `excTaken` or `excCount`.

## Test plan

- **Reset and sequential fetch**: hold `rst_n` = 0 for 2 cycles with `pcEnable` = 1, then release → `pc` = 0, 4, 8, 12 on successive edges; `epc`/`cause`/`excCount` = 0.
- **Branch**: `pc` = 32'h0000_0040, `branch` = 1, `aluZero` = 1, `branchOffset` = 32'hFFFF_FFFC → next `pc` = 32'h0000_0034. Same stimulus with `aluZero` = 0 → 32'h0000_0044.
- **Jump and jr**: `pc` = 32'h1000_0000, `jump` = 1, `jumpTarget` = 26'h000_0010 → 32'h1000_0040. `jumpReg` = 1 with `jumpRegAddr` = 32'h0000_0100 and `jump` also asserted → 32'h0000_0100.
- **Overflow trap and return**: `pc` = 32'h0000_0020, `ovfTrap` = 1, `aluOverflow` = 1 → `flush` = 1 that cycle; next `pc` = 32'h0000_0180, `epc` = 32'h0000_0020, `cause` = 12, `excTaken` pulses once, `excCount` = 1. A later `eret` → `pc` = 32'h0000_0020.
- **Misaligned jr and saturation**: `jumpRegAddr` = 32'h0000_0102 → `pc` = `EXC_VECTOR`, `cause` = 4. Forcing 300 exceptions → `excCount` = 255.
- **Stall and reset mid-trap**: `pcEnable` = 0 with `ovfTrap` = `aluOverflow` = 1 → `flush` = 0 and all state unchanged. `rst_n` = 0 together with an overflow → `pc` = `RESET_PC`, `epc` = 0.

Source files
------------

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : MIPS program counter / next-address stage with overflow and
//               address-error exception capture (EPC, cause, counter).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcEnable,
  input  logic        branch,
  input  logic        aluZero,
  input  logic [31:0] branchOffset,
  input  logic        jump,
  input  logic [25:0] jumpTarget,
  input  logic        jumpReg,
  input  logic [31:0] jumpRegAddr,
  input  logic        ovfTrap,
  input  logic        aluOverflow,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic        flush,
  output logic        excTaken,
  output logic [7:0]  excCount
);

  localparam logic [4:0] c_CAUSE_OV   = 5'd12;
  localparam logic [4:0] c_CAUSE_ADEL = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [4:0]  r_cause;
  logic        r_exc_taken;
  logic [7:0]  r_exc_count;

  logic        w_ov;
  logic        w_adel;
  logic        w_exc;
  logic [4:0]  w_code;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_ov       = pcEnable & ovfTrap & aluOverflow;
  assign w_adel     = pcEnable & jumpReg & (jumpRegAddr[1:0] != 2'b00);
  assign w_exc      = w_ov | w_adel;
  assign w_code     = w_ov ? c_CAUSE_OV : c_CAUSE_ADEL;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_exc)
      w_next_pc = EXC_VECTOR;
    else if (eret)
      w_next_pc = r_epc;
    else if (jumpReg)
      w_next_pc = jumpRegAddr;
    else if (jump)
      w_next_pc = {w_pc_plus4[31:28], jumpTarget, 2'b00};
    else if (branch & aluZero)
      w_next_pc = w_pc_plus4 + {branchOffset[29:0], 2'b00};
  end

  // Reset wins over stall and over any exception raised in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_epc       <= 32'd0;
      r_cause     <= 5'd0;
      r_exc_taken <= 1'b0;
      r_exc_count <= 8'd0;
    end else if (!pcEnable) begin
      r_exc_taken <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_exc_taken <= w_exc;
      if (w_exc) begin
        r_epc   <= r_pc;
        r_cause <= w_code;
        if (r_exc_count != 8'hFF)
          r_exc_count <= r_exc_count + 8'd1;
      end
    end
  end

  assign pc       = r_pc;
  assign pcPlus4  = w_pc_plus4;
  assign epc      = r_epc;
  assign cause    = r_cause;
  assign flush    = w_exc;
  assign excTaken = r_exc_taken;
  assign excCount = r_exc_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcEnable;
  logic        branch;
  logic        aluZero;
  logic [31:0] branchOffset;
  logic        jump;
  logic [25:0] jumpTarget;
  logic        jumpReg;
  logic [31:0] jumpRegAddr;
  logic        ovfTrap;
  logic        aluOverflow;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic        flush;
  logic        excTaken;
  logic [7:0]  excCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .pcEnable(pcEnable),
    .branch(branch), .aluZero(aluZero), .branchOffset(branchOffset),
    .jump(jump), .jumpTarget(jumpTarget),
    .jumpReg(jumpReg), .jumpRegAddr(jumpRegAddr),
    .ovfTrap(ovfTrap), .aluOverflow(aluOverflow), .eret(eret),
    .pc(pc), .pcPlus4(pcPlus4), .epc(epc), .cause(cause),
    .flush(flush), .excTaken(excTaken), .excCount(excCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    branch = 0; aluZero = 0; branchOffset = '0;
    jump = 0; jumpTarget = '0; jumpReg = 0; jumpRegAddr = '0;
    ovfTrap = 0; aluOverflow = 0; eret = 0; pcEnable = 1;
  endtask

  // Advance one edge; outputs are sampled 1 ns later, then inputs go idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_pc(input logic [31:0] a);
    jumpReg = 1; jumpRegAddr = a;
    step();
  endtask

  initial begin
    idle();
    rst_n = 0;
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", {27'd0, cause}, 32'd0);
    chk("rst_cnt", {24'd0, excCount}, 32'd0);
    chk("rst_exc", {31'd0, excTaken}, 32'd0);
    rst_n = 1;
    step(); chk("seq_4", pc, 32'd4);
    step(); chk("seq_8", pc, 32'd8);
    step(); chk("seq_12", pc, 32'd12);
    chk("pcplus4", pcPlus4, 32'd16);

    load_pc(32'h40);
    branch = 1; aluZero = 1; branchOffset = 32'hFFFF_FFFC;
    step(); chk("br_taken", pc, 32'h34);
    load_pc(32'h40);
    branch = 1; aluZero = 0; branchOffset = 32'hFFFF_FFFC;
    step(); chk("br_not", pc, 32'h44);

    load_pc(32'h1000_0000);
    jump = 1; jumpTarget = 26'h10;
    step(); chk("jump", pc, 32'h1000_0040);
    jump = 1; jumpTarget = 26'h10; jumpReg = 1; jumpRegAddr = 32'h100;
    step(); chk("jr_over_j", pc, 32'h100);

    load_pc(32'h20);
    ovfTrap = 1; aluOverflow = 1;
    #1 chk("ov_flush", {31'd0, flush}, 32'd1);
    step();
    chk("ov_pc", pc, 32'h180);
    chk("ov_epc", epc, 32'h20);
    chk("ov_cause", {27'd0, cause}, 32'd12);
    chk("ov_exc", {31'd0, excTaken}, 32'd1);
    chk("ov_cnt", {24'd0, excCount}, 32'd1);
    step();
    chk("ov_pulse_end", {31'd0, excTaken}, 32'd0);
    chk("ov_pc_next", pc, 32'h184);
    eret = 1;
    step();
    chk("eret_pc", pc, 32'h20);
    chk("eret_exc", {31'd0, excTaken}, 32'd0);
    chk("eret_epc", epc, 32'h20);
    chk("eret_cause", {27'd0, cause}, 32'd12);

    jumpReg = 1; jumpRegAddr = 32'h102;
    #1 chk("adel_flush", {31'd0, flush}, 32'd1);
    step();
    chk("adel_pc", pc, 32'h180);
    chk("adel_cause", {27'd0, cause}, 32'd4);
    chk("adel_epc", epc, 32'h20);
    chk("adel_cnt", {24'd0, excCount}, 32'd2);
    jumpReg = 1; jumpRegAddr = 32'h102; ovfTrap = 1; aluOverflow = 1;
    step();
    chk("both_cause", {27'd0, cause}, 32'd12);
    chk("both_epc", epc, 32'h180);
    chk("b2b_exc", {31'd0, excTaken}, 32'd1);
    chk("both_cnt", {24'd0, excCount}, 32'd3);

    pcEnable = 0; ovfTrap = 1; aluOverflow = 1; jumpReg = 1; jumpRegAddr = 32'h0;
    #1 chk("stall_flush", {31'd0, flush}, 32'd0);
    step();
    chk("stall_pc", pc, 32'h180);
    chk("stall_epc", epc, 32'h180);
    chk("stall_cnt", {24'd0, excCount}, 32'd3);
    chk("stall_exc", {31'd0, excTaken}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      ovfTrap = 1; aluOverflow = 1;
      step();
    end
    chk("sat_cnt", {24'd0, excCount}, 32'd255);

    load_pc(32'hFFFF_FFFC);
    chk("wrap_p4", pcPlus4, 32'h0);
    step(); chk("wrap_pc", pc, 32'h0);

    load_pc(32'h60);
    rst_n = 0; ovfTrap = 1; aluOverflow = 1;
    step();
    chk("rst_ov_pc", pc, 32'h0);
    chk("rst_ov_epc", epc, 32'h0);
    chk("rst_ov_cnt", {24'd0, excCount}, 32'd0);
    chk("rst_ov_exc", {31'd0, excTaken}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
